// File: rtl/vram_dma_pkg.sv
// Shared definitions for the VRAM fill/copy DMA: FSM encoding, op codes and
// the 48-bit VRAM data word packing.
package vram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        WR_REQ = 3'd2,
        GAP    = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    localparam int VRAM_DATA_W = 48;
    localparam int VRAM_WORD_W = 16;

    // Payload lives in [15:0]; the upper bits of the controller word are unused.
    function automatic logic [VRAM_DATA_W-1:0] pack_vram(input logic [VRAM_WORD_W-1:0] data);
        return {32'h0, data};
    endfunction

endpackage

// File: rtl/vram_dma_bus_txn.sv
// Single VRAM bus transaction engine: registered strobe/address/data, ACK
// qualification window, read capture and per-transaction timeout.
module vram_dma_bus_txn
    import vram_dma_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WR_ACK_SKIP = 2,
    parameter int RD_WAIT     = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_50mhz,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [VRAM_WORD_W-1:0] i_wdata,
    input  logic                   i_ack,
    input  logic [VRAM_DATA_W-1:0] i_douta,
    output logic                   o_stb,
    output logic                   o_we,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [VRAM_DATA_W-1:0] o_dina,
    output logic                   o_done,
    output logic                   o_timeout,
    output logic [VRAM_WORD_W-1:0] o_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SKIP_C = CNT_W'(WR_ACK_SKIP);
    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);

    logic                   r_stb;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [VRAM_DATA_W-1:0] r_dina;
    logic [CNT_W-1:0]       r_cnt;
    logic [VRAM_WORD_W-1:0] r_rdata;

    logic w_window_open;
    logic w_done;
    logic w_timeout;
    logic w_unused_douta;

    // The controller raises a stale ACK early in a write; only trust it once
    // the skip window has elapsed (reads need their own settle time).
    assign w_window_open  = r_we ? (r_cnt >= SKIP_C) : (r_cnt >= WAIT_C);
    assign w_done         = r_stb & i_ack & w_window_open;
    assign w_timeout      = r_stb & ~w_done & (r_cnt == TO_C);
    assign w_unused_douta = ^i_douta[VRAM_DATA_W-1:VRAM_WORD_W];

    // A new start is only taken with the strobe low, so consecutive
    // transactions always see at least one idle bus cycle.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_dina  <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else if (r_stb) begin
            if (w_done || w_timeout) begin
                r_stb <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done && !r_we) begin
                r_rdata <= i_douta[VRAM_WORD_W-1:0];
            end
        end else if (i_start) begin
            r_stb  <= 1'b1;
            r_we   <= i_we;
            r_addr <= i_addr;
            r_dina <= pack_vram(i_wdata);
            r_cnt  <= '0;
        end
    end

    assign o_stb     = r_stb;
    assign o_we      = r_we;
    assign o_addr    = r_addr;
    assign o_dina    = r_dina;
    assign o_done    = w_done;
    assign o_timeout = w_timeout;
    assign o_rdata   = r_rdata;

endmodule

// File: rtl/vram_dma.sv
// VRAM fill/copy DMA: accepts one command at a time and sequences single-word
// read/write transactions on the SRAM controller VRAM port.
module vram_dma
    import vram_dma_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int LEN_W       = 16,
    parameter int WR_ACK_SKIP = 2,
    parameter int RD_WAIT     = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_50mhz,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [ADDR_W-1:0]      cmd_src,
    input  logic [ADDR_W-1:0]      cmd_dst,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [VRAM_WORD_W-1:0] cmd_fill,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [LEN_W-1:0]       words_done,
    output logic                   v_stb,
    output logic                   v_we,
    output logic [ADDR_W-1:0]      v_addra,
    output logic [VRAM_DATA_W-1:0] v_dina,
    input  logic [VRAM_DATA_W-1:0] v_douta,
    input  logic                   v_ACK,
    output logic [2:0]             o_dbg_state
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_op;
    logic [ADDR_W-1:0]      r_src;
    logic [ADDR_W-1:0]      r_dst;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_words;
    logic [VRAM_WORD_W-1:0] r_fill;
    logic                   r_after_rd;
    logic                   r_done;
    logic                   r_error;

    logic                   w_start;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_addr;
    logic [VRAM_WORD_W-1:0] w_wdata;
    logic                   w_txn_done;
    logic                   w_txn_to;
    logic [VRAM_WORD_W-1:0] w_rdata;

    vram_dma_bus_txn #(
        .ADDR_W      (ADDR_W),
        .WR_ACK_SKIP (WR_ACK_SKIP),
        .RD_WAIT     (RD_WAIT),
        .TIMEOUT     (TIMEOUT)
    ) u_txn (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .i_start   (w_start),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_ack     (v_ACK),
        .i_douta   (v_douta),
        .o_stb     (v_stb),
        .o_we      (v_we),
        .o_addr    (v_addra),
        .o_dina    (v_dina),
        .o_done    (w_txn_done),
        .o_timeout (w_txn_to),
        .o_rdata   (w_rdata)
    );

    // Transactions are launched from IDLE and GAP only, so the first strobe
    // rises on the accept edge and GAP is the single low cycle between words.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_we    = 1'b0;
        w_addr  = r_dst;
        w_wdata = r_fill;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_next = FIN;
                    end else begin
                        w_start = 1'b1;
                        w_we    = (cmd_op == OP_FILL);
                        w_addr  = (cmd_op == OP_COPY) ? cmd_src : cmd_dst;
                        w_wdata = cmd_fill;
                        w_next  = (cmd_op == OP_COPY) ? RD_REQ : WR_REQ;
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (w_txn_to) begin
                    w_next = FIN;
                end else if (w_txn_done) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (r_after_rd) begin
                    w_start = 1'b1;
                    w_we    = 1'b1;
                    w_wdata = w_rdata;
                    w_next  = WR_REQ;
                end else if (r_words == r_len) begin
                    w_next = FIN;
                end else if (r_op == OP_COPY) begin
                    w_start = 1'b1;
                    w_addr  = r_src;
                    w_next  = RD_REQ;
                end else begin
                    w_start = 1'b1;
                    w_we    = 1'b1;
                    w_next  = WR_REQ;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_FILL;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_words    <= '0;
            r_fill     <= '0;
            r_after_rd <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_src      <= cmd_src;
                        r_dst      <= cmd_dst;
                        r_len      <= cmd_len;
                        r_fill     <= cmd_fill;
                        r_words    <= '0;
                        r_error    <= 1'b0;
                        r_after_rd <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (w_txn_to) begin
                        r_error <= 1'b1;
                    end else if (w_txn_done) begin
                        r_after_rd <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (w_txn_to) begin
                        r_error <= 1'b1;
                    end else if (w_txn_done) begin
                        r_words    <= r_words + LEN_W'(1);
                        r_src      <= r_src + ADDR_W'(1);
                        r_dst      <= r_dst + ADDR_W'(1);
                        r_after_rd <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign error       = r_error;
    assign words_done  = r_words;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: a controller responder with stale write ACKs,
// a queue-based model of expected bus writes/reads, and literal spot checks.
module tb_vram_dma;

    localparam int TIMEOUT = 255;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [19:0] cmd_src;
    logic [19:0] cmd_dst;
    logic [15:0] cmd_len;
    logic [15:0] cmd_fill;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic        v_stb;
    logic        v_we;
    logic [19:0] v_addra;
    logic [47:0] v_dina;
    logic [47:0] v_douta = '0;
    logic        v_ACK = 1'b0;
    logic [2:0]  dbg_state;

    always #10 clk_50mhz = ~clk_50mhz;

    vram_dma dut (
        .clk_50mhz   (clk_50mhz),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_fill    (cmd_fill),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_done  (words_done),
        .v_stb       (v_stb),
        .v_we        (v_we),
        .v_addra     (v_addra),
        .v_dina      (v_dina),
        .v_douta     (v_douta),
        .v_ACK       (v_ACK),
        .o_dbg_state (dbg_state)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: {addr, 48-bit write data} for writes, addresses for reads.
    logic [67:0] exp_q[$];
    logic [19:0] exp_rd_q[$];
    logic [15:0] mem [logic [19:0]];

    function automatic logic [15:0] rd_mem(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        case (a)
            20'h80010: return 16'h1111;
            20'h80011: return 16'h2222;
            20'h80012: return 16'h3333;
            default:   return 16'h0000;
        endcase
    endfunction

    // Expected bus traffic for a command: word i goes to dst+i (mod 2^20),
    // carrying the fill value or the word read from src+i.
    task automatic model_cmd(input logic op, input logic [19:0] src, input logic [19:0] dst,
                             input logic [15:0] fill, input int n_wr, input int n_rd);
        for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(src + 20'(i));
        for (int i = 0; i < n_wr; i++) begin
            logic [19:0] wa;
            logic [15:0] wd;
            wa = dst + 20'(i);
            wd = op ? rd_mem(src + 20'(i)) : fill;
            exp_q.push_back({wa, 32'h0, wd});
        end
    endtask

    // Controller responder + per-cycle bus monitor.
    int          k = 0;
    int          slen;
    int          wr_n = 0;
    int          n_rise = 0;
    int          hang_wr = -1;
    logic        cur_hang = 1'b0;
    logic        ack_real = 1'b0;
    logic        p_stb = 1'b0;
    logic        p_we = 1'b0;
    logic        p_hang = 1'b0;
    logic        p_ack_real = 1'b0;
    logic [19:0] p_addr = '0;
    logic [47:0] p_dina = '0;
    logic [19:0] last_wr_addr = '0;

    initial forever begin
        @(posedge clk_50mhz);
        #1;
        if (!rst && p_stb && !v_stb) begin
            slen = k + 1;
            if (p_we) begin
                if (p_hang) check("timeout_strobe_len", (slen >= TIMEOUT && slen <= TIMEOUT + 1), 1);
                else check("wr_strobe_len", slen, 5);
                if (p_ack_real) begin
                    mem[p_addr] = p_dina[15:0];
                    last_wr_addr = p_addr;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_write: addr %05h data %012h, none expected", p_addr, p_dina);
                    end else begin
                        check("write", {p_addr, p_dina}, exp_q.pop_front());
                    end
                end
            end else begin
                check("rd_strobe_len", slen, 2);
                if (exp_rd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_read: addr %05h, none expected", p_addr);
                end else begin
                    check("read_addr", p_addr, exp_rd_q.pop_front());
                end
            end
        end
        if (v_stb) begin
            if (p_stb) begin
                k++;
                check("bus_stable", {v_we, v_addra, v_dina}, {p_we, p_addr, p_dina});
            end else begin
                k = 0;
                n_rise++;
                if (v_we) wr_n++;
                cur_hang = v_we && (wr_n == hang_wr);
            end
            if (v_we) begin
                v_ACK   = !cur_hang && (k == 0 || k == 4);
                v_douta = '0;
            end else begin
                v_ACK   = 1'b1;
                v_douta = (k == 0) ? 48'hFFFF_FFFF_DEAD : {32'hA5A5_5A5A, rd_mem(v_addra)};
            end
            ack_real = v_we && v_ACK && (k == 4);
        end else begin
            v_ACK    = 1'b0;
            v_douta  = '0;
            ack_real = 1'b0;
        end
        p_stb      = v_stb;
        p_we       = v_we;
        p_addr     = v_addra;
        p_dina     = v_dina;
        p_hang     = cur_hang;
        p_ack_real = ack_real;
    end

    task automatic issue(input logic op, input logic [19:0] src, input logic [19:0] dst,
                         input logic [15:0] len, input logic [15:0] fill);
        @(negedge clk_50mhz);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill;
        cmd_valid = 1'b1;
        @(negedge clk_50mhz);
        cmd_valid = 1'b0;
    endtask

    // lat = clock edges from the accept edge (inclusive) until done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clk_50mhz);
            lat++;
        end
        check("done_seen", done, 1);
        @(negedge clk_50mhz);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    int lat;
    int base;
    logic seen_done;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = '0;
        repeat (3) @(negedge clk_50mhz);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words_done", words_done, 0);
        check("rst_v_stb", v_stb, 0);
        check("rst_v_we", v_we, 0);
        check("rst_v_addra", v_addra, 0);
        check("rst_v_dina", v_dina, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Fill: 6 cycles per word, plus GAP->FIN and FIN->done.
        model_cmd(1'b0, 20'h0, 20'h80000, 16'hF800, 4, 0);
        issue(1'b0, 20'h0, 20'h80000, 16'd4, 16'hF800);
        wait_done(lat);
        check("fill_latency", lat, 26);
        check("fill_words_done", words_done, 4);
        check("fill_error", error, 0);
        check("fill_mem_first", rd_mem(20'h80000), 16'hF800);
        check("fill_mem_last", rd_mem(20'h80003), 16'hF800);
        check("fill_all_writes", exp_q.size(), 0);

        // Copy 3 words.
        model_cmd(1'b1, 20'h80010, 20'h80100, 16'h0, 3, 3);
        issue(1'b1, 20'h80010, 20'h80100, 16'd3, 16'h0);
        wait_done(lat);
        check("copy_mem0", rd_mem(20'h80100), 16'h1111);
        check("copy_mem1", rd_mem(20'h80101), 16'h2222);
        check("copy_mem2", rd_mem(20'h80102), 16'h3333);
        check("copy_error", error, 0);
        check("copy_words_done", words_done, 3);
        check("copy_all_traffic", exp_q.size() + exp_rd_q.size(), 0);

        // Zero length: no strobe, done two edges after accept.
        base = n_rise;
        issue(1'b0, 20'h0, 20'h00050, 16'd0, 16'hABCD);
        wait_done(lat);
        check("zero_latency", lat, 2);
        check("zero_words_done", words_done, 0);
        check("zero_no_strobe", n_rise - base, 0);

        // Timeout on the second write of a 3-word fill.
        hang_wr = wr_n + 2;
        model_cmd(1'b0, 20'h0, 20'h40000, 16'h001F, 1, 0);
        issue(1'b0, 20'h0, 20'h40000, 16'd3, 16'h001F);
        wait_done(lat);
        check("to_error", error, 1);
        check("to_words_done", words_done, 1);
        check("to_all_writes", exp_q.size(), 0);
        hang_wr = -1;
        issue(1'b0, 20'h0, 20'h00060, 16'd0, 16'h0);
        check("error_cleared_on_accept", error, 0);
        wait_done(lat);

        // Address wrap, with an ignored command mid-transfer.
        model_cmd(1'b0, 20'h0, 20'hFFFFE, 16'h07E0, 4, 0);
        issue(1'b0, 20'h0, 20'hFFFFE, 16'd4, 16'h07E0);
        repeat (8) @(negedge clk_50mhz);
        check("busy_cmd_ready", cmd_ready, 0);
        check("busy_busy", busy, 1);
        cmd_dst = 20'h12345; cmd_len = 16'd1; cmd_valid = 1'b1;
        @(negedge clk_50mhz);
        cmd_valid = 1'b0;
        wait_done(lat);
        check("wrap_words_done", words_done, 4);
        check("wrap_last_addr", last_wr_addr, 20'h00001);
        check("wrap_mem_ffff", rd_mem(20'hFFFFF), 16'h07E0);
        check("wrap_mem_0000", rd_mem(20'h00000), 16'h07E0);
        check("wrap_all_writes", exp_q.size(), 0);

        // Reset during the second write of a copy.
        base = wr_n;
        model_cmd(1'b1, 20'h80010, 20'h80200, 16'h0, 1, 2);
        issue(1'b1, 20'h80010, 20'h80200, 16'd3, 16'h0);
        for (int i = 0; i < 200 && !(wr_n == base + 2 && v_stb); i++) @(negedge clk_50mhz);
        check("reached_word2_write", (wr_n == base + 2) && v_stb, 1);
        rst = 1'b1;
        @(negedge clk_50mhz);
        check("rstmid_v_stb", v_stb, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        check("rstmid_done", done, 0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk_50mhz);
            if (done) seen_done = 1'b1;
        end
        check("rstmid_no_done", seen_done, 0);
        check("rstmid_traffic", exp_q.size() + exp_rd_q.size(), 0);
        check("rstmid_mem0", rd_mem(20'h80200), 16'h1111);
        check("rstmid_mem1_unwritten", rd_mem(20'h80201), 16'h0000);

        model_cmd(1'b0, 20'h0, 20'h00100, 16'hBEEF, 1, 0);
        issue(1'b0, 20'h0, 20'h00100, 16'd1, 16'hBEEF);
        wait_done(lat);
        check("post_rst_latency", lat, 8);
        check("post_rst_words_done", words_done, 1);
        check("post_rst_mem", rd_mem(20'h00100), 16'hBEEF);
        check("final_all_writes", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Bus initiator for the VRAM port (v_stb/v_we/v_addra/v_dina/v_douta/v_ACK) of the SRAM controller.
- Executes fill and copy commands on 16-bit VRAM words so that screen clear and scroll need no CPU loop.
- Issues one bus transaction at a time and tolerates the controller's read-modify-write ACK timing.
- Sits between a command register block and the SRAM controller VRAM port.

Parameters:
- ADDR_W, 20: VRAM word address width.
- LEN_W, 16: transfer length width, in words.
- WR_ACK_SKIP, 2: cycles after write strobe assertion during which v_ACK is ignored.
- RD_WAIT, 1: cycles after read strobe assertion before v_ACK/v_douta are sampled.
- TIMEOUT, 255: maximum wait cycles for ACK per transaction.

Ports:
- clk_50mhz, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: high only in IDLE.
- cmd_op, in, 1: 0 = fill, 1 = copy.
- cmd_src, in, ADDR_W: copy source start address; ignored for fill.
- cmd_dst, in, ADDR_W: destination start address.
- cmd_len, in, LEN_W: word count.
- cmd_fill, in, 16: fill value.
- busy, out, 1: high whenever the FSM is not in IDLE.
- done, out, 1: one-cycle pulse at completion or error.
- error, out, 1: timeout flag; holds until the next accepted command or rst.
- words_done, out, LEN_W: count of completed writes; holds after done.
- v_stb, out, 1: bus strobe.
- v_we, out, 1: bus write enable.
- v_addra, out, ADDR_W: bus address.
- v_dina, out, 48: bus write data, driven as {32'h0, data16}.
- v_douta, in, 48: bus read data; bits [15:0] are used.
- v_ACK, in, 1: bus acknowledge, level signal.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, error=0, words_done=0, v_stb=0, v_we=0, v_addra=0, v_dina=0, FSM=IDLE. rst mid-transfer: v_stb=0 on the following cycle; the partial transfer is abandoned and no done pulse is issued.
- FSM states: IDLE, RD_REQ, WR_REQ, GAP, FIN.
- IDLE: accept on cmd_valid & cmd_ready. Latch src, dst, len, op, fill. Clear error and words_done.
  - len==0: go to FIN; no bus activity.
  - else: go to RD_REQ if copy, WR_REQ if fill.
- RD_REQ: v_stb=1, v_we=0, v_addra=src.
  - Wait counter starts at 0 on entry.
  - Once the counter ≥ RD_WAIT and v_ACK=1: latch v_douta[15:0], deassert v_stb next cycle, go to WR_REQ via GAP.
- WR_REQ: v_stb=1, v_we=1, v_addra=dst, v_dina={32'h0, data}. data is cmd_fill for fill, the latched read word for copy.
  - v_ACK is ignored while the counter < WR_ACK_SKIP. The controller shows a stale ACK in its first write cycle.
  - First v_ACK=1 after the skip completes the write.
  - On completion: words_done+1, src+1, dst+1; go to GAP.
- GAP: v_stb=0 for exactly one cycle. This is mandatory between all transactions; a held strobe re-triggers the controller's write sequence.
  - After GAP: go to FIN if words_done==len, else RD_REQ (copy) or WR_REQ (fill).
- FIN: done=1 for one cycle, then IDLE.
- Timeout: if the wait counter reaches TIMEOUT in RD_REQ or WR_REQ, drop v_stb, set error=1, go to FIN. words_done is not incremented for the failed word.
- Address arithmetic: modulo 2^ADDR_W. 0xFFFFF+1 wraps to 0x00000 with no error.
- v_addra, v_we, v_dina are registered and stable for the whole strobe; they change only while v_stb=0.
- cmd_valid while busy is ignored; no queueing.
- Overlapping copy regions: forward order only; no overlap detection.
- Cycles per fill word: 1 GAP + ≥(WR_ACK_SKIP+1) strobe cycles. Against the reference controller timing this is 6 cycles per word.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE=0, RD_REQ=1, WR_REQ=2, GAP=3, FIN=4;
  - the op codes OP_FILL=0, OP_COPY=1;
  - the 48-bit VRAM data packing (16-bit payload in [15:0]).
- One sub-module is natural: bus_txn, a single-transaction engine. It owns the strobe, skip/wait counter, timeout and GAP, with a start/we/addr/wdata input and a done/rdata/timeout output. vram_dma sequences it.

Test Plan:
- Fill: dst=0x80000, len=4, fill=0xF800, responder modelling the controller write ACK (1,0,0,0,1) -> 4 writes of {32'h0, 16'hF800} to 0x80000–0x80003. v_stb low ≥1 cycle between writes. done pulse. words_done=4. No write accepted during a stale-ACK cycle.
- Copy: src=0x80010 holding 0x1111/0x2222/0x3333, dst=0x80100, len=3 -> alternating read/write; 0x80100–0x80102 equal 0x1111, 0x2222, 0x3333. done, error=0.
- Zero length: len=0 -> v_stb never asserted; done 2 cycles after accept; words_done=0.
- Timeout: v_ACK held 0 on the second write of a fill len=3 -> v_stb dropped after TIMEOUT cycles; error=1; words_done=1; done pulse. Next accepted command clears error.
- Wrap and busy: fill dst=0xFFFFE, len=4 -> writes to 0xFFFFE, 0xFFFFF, 0x00000, 0x00001. A cmd_valid pulse mid-transfer is ignored (cmd_ready=0).
- Reset mid-copy: assert rst during WR_REQ of word 2 -> next cycle v_stb=0, busy=0, cmd_ready=1, no done pulse. A new fill len=1 then completes normally.
